adc_spi_responder: RTL and testbench

- Synthesizable, aclk-domain emulator of the ADC end of the SPI link that axis_exp_adc drives.
- Answers CNV/BUSY, streams conversion results on 1/2/4 SDO lanes, and decodes the register-access, lane-mode and exit commands.
- Placed in loopback builds and simulations in place of the physical ADC. Conversion samples come from an AXI-Stream source, or from a fixed pattern when none is offered.

---
 rtl/adc_spi_responder.sv | 141 ++++++++++++++
 tb/tb_adc_spi_responder.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/adc_spi_responder.sv
// adc_spi_responder: aclk-domain ADC emulator answering CNV/BUSY, streaming samples on SDO lanes and decoding mode commands.
module adc_spi_responder #(
  parameter int NUM_SDO = 4,
  parameter int DATA_WIDTH = 32,
  parameter int CNV_CYCLES = 14,
  parameter logic [DATA_WIDTH-1:0] TEST_PATTERN = 32'h8BADF00D
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  spi_cnv,
  output logic                  spi_busy,
  input  logic                  spi_sck,
  input  logic                  spi_csn,
  input  logic                  spi_sdi,
  output logic [NUM_SDO-1:0]    spi_sdo,
  input  logic                  spi_resetn,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  output logic                  reg_mode,
  output logic [1:0]            lane_md,
  output logic                  overrun
);
  localparam int CW = $clog2(CNV_CYCLES + 1);
  localparam int RW = $clog2(DATA_WIDTH + 1);
  logic [2:0] cnv_q, sck_q, csn_q;
  logic [1:0] sdi_q, rn_q;
  logic [CW-1:0] cnt;
  logic [RW-1:0] rcnt, rcnt_nxt, beats;
  logic [DATA_WIDTH-1:0] sample, shreg, shifted;
  logic [23:0] cmd;
  logic [4:0] bcnt;
  logic [2:0] w;
  logic [3:0] cur_top, nxt_top;
  logic data_ready, cnv_rise, sck_rise, csn_fall, csn_rise, csn_low, rd_en;
  always_comb begin
    cnv_rise = cnv_q[1] & ~cnv_q[2];
    sck_rise = sck_q[1] & ~sck_q[2];
    csn_fall = ~csn_q[1] & csn_q[2];
    csn_rise = csn_q[1] & ~csn_q[2];
    csn_low = ~csn_q[1];
    rd_en = ~reg_mode & data_ready;
    w = (lane_md == 2'b10 && NUM_SDO >= 4) ? 3'd4 : ((lane_md[1] ^ lane_md[0]) && NUM_SDO >= 2) ? 3'd2 : 3'd1;
    shifted = shreg << w;
    cur_top = w == 3'd4 ? shreg[DATA_WIDTH-1 -: 4] : w == 3'd2 ? {2'b0, shreg[DATA_WIDTH-1 -: 2]} : {3'b0, shreg[DATA_WIDTH-1]};
    nxt_top = w == 3'd4 ? shifted[DATA_WIDTH-1 -: 4] : w == 3'd2 ? {2'b0, shifted[DATA_WIDTH-1 -: 2]} : {3'b0, shifted[DATA_WIDTH-1]};
    beats = w == 3'd4 ? RW'(DATA_WIDTH / 4) : w == 3'd2 ? RW'(DATA_WIDTH / 2) : RW'(DATA_WIDTH);
    rcnt_nxt = rcnt + 1'b1;
  end
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      cnv_q <= '0;
      sck_q <= '0;
      csn_q <= '1;
      sdi_q <= '0;
      rn_q <= '0;
      spi_busy <= 1'b0;
      spi_sdo <= '0;
      s_axis_tready <= 1'b0;
      reg_mode <= 1'b0;
      lane_md <= 2'b00;
      overrun <= 1'b0;
      data_ready <= 1'b0;
      cmd <= '0;
      bcnt <= '0;
      shreg <= '0;
      sample <= '0;
      rcnt <= '0;
      cnt <= '0;
    end else begin
      cnv_q <= {cnv_q[1:0], spi_cnv};
      sck_q <= {sck_q[1:0], spi_sck};
      csn_q <= {csn_q[1:0], spi_csn};
      sdi_q <= {sdi_q[0], spi_sdi};
      rn_q <= {rn_q[0], spi_resetn};
      s_axis_tready <= 1'b0;
      if (!rn_q[1]) begin
        spi_busy <= 1'b0;
        spi_sdo <= '0;
        reg_mode <= 1'b0;
        lane_md <= 2'b00;
        data_ready <= 1'b0;
        cmd <= '0;
        bcnt <= '0;
        shreg <= '0;
        rcnt <= '0;
        cnt <= '0;
      end else begin
        if (csn_fall) begin
          cmd <= '0;
          bcnt <= '0;
          rcnt <= '0;
          if (rd_en) spi_sdo <= cur_top[NUM_SDO-1:0];
        end
        if (sck_rise && csn_low) begin
          cmd <= {cmd[22:0], sdi_q[1]};
          if (bcnt != 5'd24) bcnt <= bcnt + 1'b1;
          if (rd_en) begin
            shreg <= shifted;
            rcnt <= rcnt_nxt;
            if (rcnt_nxt == beats) begin
              data_ready <= 1'b0;
              spi_sdo <= '0;
            end else
              spi_sdo <= nxt_top[NUM_SDO-1:0];
          end
        end
        if (csn_rise) begin
          spi_sdo <= '0;
          if (rd_en) data_ready <= 1'b0;
          if (bcnt == 5'd24) begin
            if (!reg_mode && cmd[23:21] == 3'b101) reg_mode <= 1'b1;
            if (reg_mode && cmd[23:8] == 16'h8020) lane_md <= cmd[7:6];
            if (reg_mode && cmd[23:8] == 16'h8014 && cmd[0]) reg_mode <= 1'b0;
          end
        end
        if (cnv_rise) begin
          if (reg_mode || spi_busy)
            overrun <= 1'b1;
          else begin
            spi_busy <= 1'b1;
            cnt <= CW'(CNV_CYCLES - 1);
            sample <= s_axis_tvalid ? s_axis_tdata : TEST_PATTERN;
            s_axis_tready <= s_axis_tvalid;
          end
        end
        // completion comes last so a fresh sample wins over a same-cycle shift or abort
        if (spi_busy) begin
          if (cnt == '0) begin
            spi_busy <= 1'b0;
            shreg <= sample;
            data_ready <= 1'b1;
            rcnt <= '0;
            if (data_ready || csn_low) overrun <= 1'b1;
          end else
            cnt <= cnt - 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_adc_spi_responder.sv
// tb_adc_spi_responder: directed checks of mode commands, conversions, lane readout, overrun and resets.
module tb_adc_spi_responder;
  logic aclk, aresetn, spi_cnv, spi_busy, spi_sck, spi_csn, spi_sdi, spi_resetn;
  logic [3:0] spi_sdo;
  logic [31:0] s_axis_tdata;
  logic s_axis_tvalid, s_axis_tready, reg_mode, overrun;
  logic [1:0] lane_md;
  int checks = 0;
  int failures = 0;
  int busy_n, rdy_n;
  logic [31:0] rd;

  adc_spi_responder dut (
    .aclk(aclk), .aresetn(aresetn), .spi_cnv(spi_cnv), .spi_busy(spi_busy),
    .spi_sck(spi_sck), .spi_csn(spi_csn), .spi_sdi(spi_sdi), .spi_sdo(spi_sdo),
    .spi_resetn(spi_resetn), .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready), .reg_mode(reg_mode), .lane_md(lane_md), .overrun(overrun)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic tick(input int n);
    repeat (n) @(posedge aclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic frame(input logic [23:0] v, input int n);
    spi_csn = 1'b0;
    tick(4);
    for (int i = n - 1; i >= 0; i--) begin
      spi_sdi = v[i];
      tick(2);
      spi_sck = 1'b1;
      tick(2);
      spi_sck = 1'b0;
    end
    tick(2);
    spi_csn = 1'b1;
    tick(6);
  endtask

  task automatic read_out(input int w, input int beats, output logic [31:0] v);
    logic [3:0] mask;
    mask = w == 4 ? 4'hF : w == 2 ? 4'h3 : 4'h1;
    v = '0;
    spi_csn = 1'b0;
    tick(4);
    for (int k = 0; k < beats; k++) begin
      v = (v << w) | {28'b0, spi_sdo & mask};
      spi_sck = 1'b1;
      tick(2);
      spi_sck = 1'b0;
      tick(2);
    end
  endtask

  task automatic convert(output int nb, output int nr);
    nb = 0;
    nr = 0;
    spi_cnv = 1'b1;
    for (int i = 0; i < 40; i++) begin
      tick(1);
      if (i == 2) spi_cnv = 1'b0;
      nb += int'(spi_busy);
      nr += int'(s_axis_tready);
    end
  endtask

  initial begin
    aresetn = 1'b0;
    spi_resetn = 1'b1;
    spi_cnv = 1'b0;
    spi_sck = 1'b0;
    spi_csn = 1'b1;
    spi_sdi = 1'b0;
    s_axis_tdata = '0;
    s_axis_tvalid = 1'b0;
    tick(3);
    chk("rst_busy", {31'b0, spi_busy}, 0);
    chk("rst_sdo", {28'b0, spi_sdo}, 0);
    chk("rst_tready", {31'b0, s_axis_tready}, 0);
    chk("rst_reg_mode", {31'b0, reg_mode}, 0);
    chk("rst_lane_md", {30'b0, lane_md}, 0);
    chk("rst_overrun", {31'b0, overrun}, 0);
    aresetn = 1'b1;
    tick(4);

    frame(24'hA00000, 24);
    chk("enter_reg_mode", {31'b0, reg_mode}, 1);
    frame(24'h802080, 24);
    chk("lane_md_4", {30'b0, lane_md}, 2);
    frame(24'h801401, 24);
    chk("exit_reg_mode", {31'b0, reg_mode}, 0);
    chk("lane_md_kept", {30'b0, lane_md}, 2);
    frame(24'h00A000, 16);
    chk("short_frame_mode", {31'b0, reg_mode}, 0);
    chk("short_frame_lanes", {30'b0, lane_md}, 2);

    convert(busy_n, rdy_n);
    chk("pat_busy_len", busy_n, 14);
    chk("pat_no_tready", rdy_n, 0);
    read_out(4, 8, rd);
    chk("pat_read4", rd, 32'h8BADF00D);
    chk("pat_sdo_idle", {28'b0, spi_sdo}, 0);
    spi_csn = 1'b1;
    tick(4);
    chk("pat_overrun", {31'b0, overrun}, 0);

    s_axis_tdata = 32'h0023FF42;
    s_axis_tvalid = 1'b1;
    convert(busy_n, rdy_n);
    s_axis_tvalid = 1'b0;
    chk("strm_busy_len", busy_n, 14);
    chk("strm_tready_once", rdy_n, 1);
    read_out(4, 8, rd);
    chk("strm_read4", rd, 32'h0023FF42);
    spi_csn = 1'b1;
    tick(4);

    frame(24'hA00000, 24);
    frame(24'h802000, 24);
    frame(24'h801401, 24);
    chk("lane_md_1", {30'b0, lane_md}, 0);
    chk("back_to_conv", {31'b0, reg_mode}, 0);
    s_axis_tvalid = 1'b1;
    convert(busy_n, rdy_n);
    s_axis_tvalid = 1'b0;
    chk("strm1_tready_once", rdy_n, 1);
    read_out(1, 32, rd);
    chk("strm_read1", rd, 32'h0023FF42);
    chk("strm1_sdo_idle", {28'b0, spi_sdo}, 0);
    spi_csn = 1'b1;
    tick(4);
    chk("strm1_overrun", {31'b0, overrun}, 0);

    convert(busy_n, rdy_n);
    chk("ovr_after_one", {31'b0, overrun}, 0);
    convert(busy_n, rdy_n);
    chk("ovr_after_two", {31'b0, overrun}, 1);
    busy_n = 0;
    spi_cnv = 1'b1;
    for (int i = 0; i < 40; i++) begin
      tick(1);
      if (i == 2 || i == 8) spi_cnv = 1'b0;
      if (i == 6) spi_cnv = 1'b1;
      busy_n += int'(spi_busy);
    end
    chk("busy_not_extended", busy_n, 14);
    read_out(1, 3, rd);
    chk("abort_partial", rd, 32'h4);
    spi_csn = 1'b1;
    tick(4);
    chk("abort_sdo", {28'b0, spi_sdo}, 0);
    read_out(1, 4, rd);
    chk("abort_discarded", rd, 0);
    spi_csn = 1'b1;
    tick(4);

    frame(24'hA00000, 24);
    frame(24'h802080, 24);
    frame(24'h801401, 24);
    chk("pre_rst_lanes", {30'b0, lane_md}, 2);
    spi_cnv = 1'b1;
    tick(2);
    spi_cnv = 1'b0;
    tick(3);
    chk("pre_rst_busy", {31'b0, spi_busy}, 1);
    spi_resetn = 1'b0;
    tick(4);
    chk("srst_busy", {31'b0, spi_busy}, 0);
    chk("srst_lane_md", {30'b0, lane_md}, 0);
    chk("srst_reg_mode", {31'b0, reg_mode}, 0);
    chk("srst_keeps_overrun", {31'b0, overrun}, 1);
    spi_resetn = 1'b1;
    tick(20);
    chk("srst_conv_lost", {31'b0, spi_busy}, 0);
    read_out(4, 2, rd);
    chk("srst_no_data", rd, 0);
    spi_csn = 1'b1;
    tick(4);
    frame(24'hA00000, 24);
    chk("reg_mode_again", {31'b0, reg_mode}, 1);
    spi_resetn = 1'b0;
    tick(4);
    chk("srst_exit_reg_mode", {31'b0, reg_mode}, 0);
    spi_resetn = 1'b1;
    tick(4);
    aresetn = 1'b0;
    tick(2);
    chk("arst_overrun", {31'b0, overrun}, 0);
    aresetn = 1'b1;
    tick(4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
